// File: rtl/fetch_sequencer.sv
// Next-PC and instruction-fetch controller for the external 20-bit PC register.
// Drives PCin/select (pc_next/pc_load), fetches over req/ack and hands words
// downstream over valid/ready, with branch redirect and memory timeout handling.
module fetch_sequencer #(
    parameter int unsigned      AW       = 20,
    parameter int unsigned      IW       = 20,
    parameter logic [AW-1:0]    RESET_PC = 20'h00000,
    parameter int unsigned      TIMEOUT  = 15,
    parameter int unsigned      CW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [AW-1:0] pc_cur,
    output logic [AW-1:0] pc_next,
    output logic          pc_load,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          fetch_err
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_ADV   = 3'd4;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    state_q,       state_d;
    logic [AW-1:0] pc_next_q,     pc_next_d;
    logic          instr_valid_q, instr_valid_d;
    logic [IW-1:0] instr_out_q,   instr_out_d;
    logic [AW-1:0] instr_pc_q,    instr_pc_d;
    logic          fetch_err_q,   fetch_err_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic          redir_pend_q,  redir_pend_d;
    logic [AW-1:0] redir_pc_q,    redir_pc_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_next_q     <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            fetch_err_q   <= 1'b0;
            cnt_q         <= '0;
            redir_pend_q  <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_next_q     <= pc_next_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            fetch_err_q   <= fetch_err_d;
            cnt_q         <= cnt_d;
            redir_pend_q  <= redir_pend_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        pc_next_d     = pc_next_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        fetch_err_d   = fetch_err_q;
        cnt_d         = cnt_q;
        redir_pend_d  = redir_pend_q;
        redir_pc_d    = redir_pc_q;

        if (redirect_valid && state_q != S_BOOT) begin
            fetch_err_d = 1'b0;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_next_d = redirect_pc;
                    state_d   = S_ADV;
                end else if (run) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    cnt_d        = '0;
                    redir_pend_d = 1'b0;
                    if (redirect_valid) begin
                        // Late redirect on the ack cycle: drop data, newest target wins
                        pc_next_d = redirect_pc;
                        state_d   = S_ADV;
                    end else if (redir_pend_q) begin
                        pc_next_d = redir_pc_q;
                        state_d   = S_ADV;
                    end else begin
                        instr_out_d   = imem_rdata;
                        instr_pc_d    = pc_cur;
                        instr_valid_d = 1'b1;
                        pc_next_d     = pc_cur + AW'(1);
                        state_d       = S_HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    redir_pend_d = 1'b0;
                    if (redirect_valid) begin
                        pc_next_d = redirect_pc;
                        state_d   = S_ADV;
                    end else begin
                        fetch_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (redirect_valid) begin
                        redir_pc_d   = redirect_pc;
                        redir_pend_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_next_d     = redirect_pc;
                    state_d       = S_ADV;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_ADV;
                end
            end
            S_ADV: begin
                if (redirect_valid) begin
                    pc_next_d = redirect_pc;
                end else if (run) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State-decoded strobes and registered outputs
    assign pc_load     = (state_q == S_BOOT) || (state_q == S_ADV);
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_cur;
    assign pc_next     = pc_next_q;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [19:0] pc_cur;
    logic [19:0] pc_next;
    logic        pc_load;
    logic        imem_req;
    logic [19:0] imem_addr;
    logic        imem_ack;
    logic [19:0] imem_rdata;
    logic        instr_valid;
    logic [19:0] instr_out;
    logic [19:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [19:0] redirect_pc;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .pc_load        (pc_load),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // External PC register: captures pc_next whenever pc_load is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_cur <= 20'h5A5A5;
        else if (pc_load) pc_cur <= pc_next;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk20(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory answers after dly idle cycles; leaves the DUT one edge past the ack
    task automatic do_fetch(input int unsigned dly, input logic [19:0] data);
        for (int i = 0; i < int'(dly); i++) step();
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 20'h0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 20'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 20'h0;
        step();
        step();
        chk1 ("rst_pc_load",  pc_load, 1'b1);
        chk1 ("rst_req",      imem_req, 1'b0);
        chk1 ("rst_valid",    instr_valid, 1'b0);
        chk20("rst_pc_next",  pc_next, 20'h00000);
        chk20("rst_instr",    instr_out, 20'h00000);
        chk1 ("rst_err",      fetch_err, 1'b0);

        // Boot and three in-order fetches
        rst_n = 1'b1; run = 1'b1; instr_ready = 1'b1;
        chk1 ("boot_load", pc_load, 1'b1);
        step();
        chk1 ("idle_noload", pc_load, 1'b0);
        chk20("boot_pc",     pc_cur, 20'h00000);
        step();
        chk1 ("f0_req",  imem_req, 1'b1);
        chk20("f0_addr", imem_addr, 20'h00000);
        do_fetch(1, 20'h0A1B2);
        chk1 ("f0_valid", instr_valid, 1'b1);
        chk20("f0_data",  instr_out, 20'h0A1B2);
        chk20("f0_pc",    instr_pc, 20'h00000);
        step();
        chk1 ("f0_adv_load", pc_load, 1'b1);
        chk20("f0_adv_next", pc_next, 20'h00001);
        chk1 ("f0_adv_valid", instr_valid, 1'b0);
        step();
        chk20("f1_addr", imem_addr, 20'h00001);
        do_fetch(1, 20'h11111);
        chk20("f1_pc",   instr_pc, 20'h00001);
        step();
        chk20("f1_adv_next", pc_next, 20'h00002);
        step();
        chk20("f2_addr", imem_addr, 20'h00002);

        // Downstream stall for 5 cycles
        instr_ready = 1'b0;
        do_fetch(0, 20'h22222);
        chk20("f2_pc", instr_pc, 20'h00002);
        for (int i = 0; i < 5; i++) begin
            step();
            chk1 ("stall_valid", instr_valid, 1'b1);
            chk20("stall_data",  instr_out, 20'h22222);
            chk1 ("stall_noload", pc_load, 1'b0);
        end
        instr_ready = 1'b1;
        step();
        chk1 ("stall_adv_load", pc_load, 1'b1);
        chk20("stall_adv_next", pc_next, 20'h00003);
        step();
        chk20("f3_addr", imem_addr, 20'h00003);

        // Redirect while waiting on ack; late data must be dropped
        redirect_valid = 1'b1; redirect_pc = 20'h00400;
        step();
        redirect_valid = 1'b0; redirect_pc = 20'h0;
        step();
        step();
        chk20("rf_addr_hold", imem_addr, 20'h00003);
        chk1 ("rf_req_hold",  imem_req, 1'b1);
        imem_ack = 1'b1; imem_rdata = 20'h12345;
        step();
        imem_ack = 1'b0; imem_rdata = 20'h0;
        chk1 ("rf_novalid", instr_valid, 1'b0);
        chk1 ("rf_load",    pc_load, 1'b1);
        chk20("rf_next",    pc_next, 20'h00400);
        step();
        chk1 ("rf_novalid2", instr_valid, 1'b0);
        chk20("rf_addr",     imem_addr, 20'h00400);

        // Redirect in HOLD with ready high the same cycle
        do_fetch(0, 20'hAAAAA);
        chk1 ("rh_valid", instr_valid, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 20'hFFFFF;
        step();
        redirect_valid = 1'b0; redirect_pc = 20'h0;
        chk1 ("rh_flush", instr_valid, 1'b0);
        chk1 ("rh_load",  pc_load, 1'b1);
        chk20("rh_next",  pc_next, 20'hFFFFF);
        step();
        chk20("wrap_addr", imem_addr, 20'hFFFFF);

        // PC wrap at the top of the address space
        do_fetch(0, 20'h0BEEF);
        chk20("wrap_pc", instr_pc, 20'hFFFFF);
        step();
        chk1 ("wrap_load", pc_load, 1'b1);
        chk20("wrap_next", pc_next, 20'h00000);
        step();
        chk20("wrap_addr0", imem_addr, 20'h00000);
        chk1 ("to_req0",    imem_req, 1'b1);

        // Timeout with no ack: 15 FETCH cycles then IDLE with sticky error
        for (int i = 0; i < 14; i++) step();
        chk1 ("to_req14", imem_req, 1'b1);
        chk1 ("to_err14", fetch_err, 1'b0);
        step();
        chk1 ("to_err",  fetch_err, 1'b1);
        chk1 ("to_req",  imem_req, 1'b0);
        chk1 ("to_noload", pc_load, 1'b0);
        run = 1'b0;
        step();
        chk1 ("to_idle_req", imem_req, 1'b0);
        chk1 ("to_sticky",   fetch_err, 1'b1);
        run = 1'b1; redirect_valid = 1'b1; redirect_pc = 20'h00800;
        step();
        redirect_valid = 1'b0; redirect_pc = 20'h0;
        chk1 ("to_clear", fetch_err, 1'b0);
        chk1 ("to_load",  pc_load, 1'b1);
        chk20("to_next",  pc_next, 20'h00800);
        step();
        chk20("to_addr",  imem_addr, 20'h00800);
        do_fetch(0, 20'h55AA5);
        chk20("to_data", instr_out, 20'h55AA5);
        chk20("to_pc",   instr_pc, 20'h00800);

        // Redirect during ADV extends pc_load; last target wins
        step();
        chk20("adv_next", pc_next, 20'h00801);
        redirect_valid = 1'b1; redirect_pc = 20'h00C00;
        step();
        redirect_valid = 1'b0; redirect_pc = 20'h0;
        chk1 ("adv2_load", pc_load, 1'b1);
        chk20("adv2_next", pc_next, 20'h00C00);
        step();
        chk20("adv2_addr", imem_addr, 20'h00C00);
        chk1 ("adv2_req",  imem_req, 1'b1);

        // Reset mid-fetch; stray ack after release is ignored
        rst_n = 1'b0;
        #1;
        chk1 ("mr_load",  pc_load, 1'b1);
        chk1 ("mr_req",   imem_req, 1'b0);
        chk20("mr_next",  pc_next, 20'h00000);
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 20'h77777;
        step();
        imem_ack = 1'b0; imem_rdata = 20'h0;
        chk1 ("mr_novalid", instr_valid, 1'b0);
        chk20("mr_instr",   instr_out, 20'h00000);
        chk1 ("mr_idle_req", imem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
